// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single datamem port: CPU MEM stage vs DMA/debug.
// Optional perf counters (cpu_stall_cnt, dma_force_cnt) under `DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_type,
  input  logic                  cpu_sext,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_we,
  input  logic [1:0]            dma_type,
  input  logic                  dma_sext,
  input  logic [DATA_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,
  output logic                  mem_we,
  output logic [1:0]            mem_type,
  output logic                  mem_sext,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           cpu_stall_cnt,
  output logic [15:0]           dma_force_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_FORCE} state_t;

  typedef struct packed {
    logic [1:0]            typ;
    logic                  sext;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);
  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  state_t     state, cur, nxt_state;
  logic [3:0] wait_cnt, wait_cur, wait_nxt;
  logic [7:0] beat_cnt, beat_nxt;
  logic       cpu_gnt;
  acc_t       cpu_acc, dma_acc, mem_acc;

  // While reset is held the arbitration behaves as a fresh IDLE cycle.
  assign cur      = rst_n ? state : S_IDLE;
  assign wait_cur = rst_n ? wait_cnt : 4'd0;

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    nxt_state = cur;
    beat_nxt  = beat_cnt;
    case (cur)
      S_IDLE: begin
        dma_gnt = dma_req & (~cpu_req | (wait_cur == WMAX));
        cpu_gnt = cpu_req & ~dma_gnt;
        if (dma_gnt & dma_lock) begin
          nxt_state = S_LOCK;
          beat_nxt  = 8'd1;
        end
      end
      S_LOCK: begin
        dma_gnt = dma_req;
        if (~dma_lock | ~dma_req)
          nxt_state = S_IDLE;
        else if ((beat_cnt + 8'd1) >= LMAX) begin
          // window of LOCK_MAX beats used up; start a fresh one
          beat_nxt = 8'd0;
          if (cpu_req) nxt_state = S_FORCE;
        end else
          beat_nxt = beat_cnt + 8'd1;
      end
      S_FORCE: begin
        cpu_gnt   = cpu_req;
        beat_nxt  = 8'd0;
        nxt_state = (dma_lock & dma_req) ? S_LOCK : S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    wait_nxt = wait_cur;
    if (~dma_req | dma_gnt)  wait_nxt = 4'd0;
    else if (wait_cur < WMAX) wait_nxt = wait_cur + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      beat_cnt   <= 8'd0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      state      <= nxt_state;
      wait_cnt   <= wait_nxt;
      beat_cnt   <= beat_nxt;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (dma_gnt & ~dma_we) dma_rdata <= mem_dout;
    end
  end

  assign cpu_acc = '{typ: cpu_type, sext: cpu_sext, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_acc = '{typ: dma_type, sext: dma_sext, addr: dma_addr, wdata: dma_wdata};
  assign mem_acc = dma_gnt ? dma_acc : cpu_acc;

  assign mem_we    = dma_gnt ? dma_we : (cpu_we & cpu_gnt);
  assign mem_type  = mem_acc.typ;
  assign mem_sext  = mem_acc.sext;
  assign mem_addr  = mem_acc.addr;
  assign mem_din   = mem_acc.wdata;
  assign cpu_rdata = mem_dout;
  assign cpu_stall = cpu_req & ~cpu_gnt;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_stall_cnt <= '0;
      dma_force_cnt <= '0;
    end else begin
      if (cpu_stall) cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
      if ((cur == S_IDLE) & dma_req & cpu_req & (wait_cur == WMAX))
        dma_force_cnt <= dma_force_cnt + 16'd1;
    end
  end
`endif

endmodule
